// File: rtl/uart_cmd_dispatcher_if.sv
// Bundle of the UART rx/tx path and the per-handler handshake lines.
// master = dispatcher side, slave = UART + handler side.
interface uart_cmd_dispatcher_if #(
  parameter int N_HANDLERS = 4
);
  localparam int SEL_W = (N_HANDLERS > 1) ? $clog2(N_HANDLERS) : 1;

  logic                       rx_ready;
  logic [7:0]                 rx_data;
  logic                       tx_active;
  logic                       tx_done;
  logic [7:0]                 tx_data;
  logic                       tx_start;
  logic [N_HANDLERS-1:0]      h_activate;
  logic [N_HANDLERS-1:0]      h_done;
  logic [N_HANDLERS-1:0]      h_rx_ready;
  logic [N_HANDLERS-1:0][7:0] h_tx_data;
  logic [N_HANDLERS-1:0]      h_tx_start;
  logic                       busy;
  logic [SEL_W-1:0]           sel;
  logic                       err_cmd;
  logic                       err_timeout;

  modport master (
    input  rx_ready, rx_data, tx_active, tx_done, h_done, h_tx_data, h_tx_start,
    output tx_data, tx_start, h_activate, h_rx_ready, busy, sel, err_cmd, err_timeout
  );

  modport slave (
    output rx_ready, rx_data, tx_active, tx_done, h_done, h_tx_data, h_tx_start,
    input  tx_data, tx_start, h_activate, h_rx_ready, busy, sel, err_cmd, err_timeout
  );
endinterface

// File: rtl/uart_cmd_dispatcher.sv
// Command front-end for the shared UART: one command byte picks a handler,
// which then owns rx/tx until it raises done or goes quiet for too long.
// Unknown commands are answered with a single NAK byte.
module uart_cmd_dispatcher #(
  parameter int         N_HANDLERS     = 4,
  parameter logic [7:0] NAK_BYTE       = 8'h15,
  parameter int         TIMEOUT_CYCLES = 12_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_cmd_dispatcher_if.master bus
);
  localparam int SEL_W = (N_HANDLERS > 1) ? $clog2(N_HANDLERS) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]       N_CMD    = 8'(N_HANDLERS);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_RELEASE, S_NAK_WAIT, S_NAK_SEND
  } state_t;

  state_t                state_q, state_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_cmd_q, err_cmd_d;
  logic                  err_to_q, err_to_d;
  logic [7:0]            tx_hold_q;
  logic [7:0]            tx_src;
  logic                  tx_start_c;
  logic [N_HANDLERS-1:0] act_c, rxr_c;
  logic                  sel_done;

  assign sel_done = bus.h_done[sel_q];

  // State register, grant index, idle counter, error pulses and tx byte hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      cnt_q     <= '0;
      err_cmd_q <= 1'b0;
      err_to_q  <= 1'b0;
      tx_hold_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      err_cmd_q <= err_cmd_d;
      err_to_q  <= err_to_d;
      if (tx_start_c) tx_hold_q <= tx_src;
    end
  end

  // Next-state decode plus the grant-dependent muxing of rx/tx.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    err_cmd_d  = 1'b0;
    err_to_d   = 1'b0;
    act_c      = '0;
    rxr_c      = '0;
    tx_start_c = 1'b0;
    tx_src     = tx_hold_q;
    case (state_q)
      S_IDLE: begin
        // The command byte itself is consumed here and never forwarded.
        if (bus.rx_ready) begin
          if (bus.rx_data < N_CMD) begin
            sel_d   = bus.rx_data[SEL_W-1:0];
            cnt_d   = '0;
            state_d = S_RUN;
          end else begin
            err_cmd_d = 1'b1;
            state_d   = S_NAK_WAIT;
          end
        end
      end
      S_RUN: begin
        act_c[sel_q] = 1'b1;
        rxr_c[sel_q] = bus.rx_ready;
        tx_src       = bus.h_tx_data[sel_q];
        tx_start_c   = bus.h_tx_start[sel_q];
        // Any traffic on the link counts as handler activity.
        if (bus.rx_ready || bus.h_tx_start[sel_q] || bus.tx_active) cnt_d = '0;
        else                                                         cnt_d = cnt_q + 1'b1;
        // done takes priority over a coincident timeout.
        if (sel_done) begin
          state_d = S_RELEASE;
        end else if (cnt_q == CNT_LAST) begin
          err_to_d = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_RELEASE: begin
        if (!sel_done) state_d = S_IDLE;
      end
      S_NAK_WAIT: begin
        if (!bus.tx_active) state_d = S_NAK_SEND;
      end
      S_NAK_SEND: begin
        tx_src     = NAK_BYTE;
        tx_start_c = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.h_activate  = act_c;
  assign bus.h_rx_ready  = rxr_c;
  assign bus.tx_start    = tx_start_c;
  assign bus.tx_data     = tx_start_c ? tx_src : tx_hold_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.sel         = sel_q;
  assign bus.err_cmd     = err_cmd_q;
  assign bus.err_timeout = err_to_q;
endmodule

// File: doc/uart_cmd_dispatcher.md
Name: uart_cmd_dispatcher

Overview:
- Front-end scheduler for the shared UART link: decodes one command byte from rx and grants exclusive use of the rx/tx path to one of N handler blocks (byte replayer, sample dump, config writer, ...).
- Drives each handler through the activate/done handshake and muxes the granted handler's tx_data/tx_start onto the UART transmitter.
- Replies with a NAK byte to unknown commands.
- Aborts a handler that stalls beyond a timeout.

Parameters:
- N_HANDLERS, 4, number of handler ports; valid command bytes are 0..N_HANDLERS-1.
- NAK_BYTE, 8'h15, byte transmitted on an invalid command.
- TIMEOUT_CYCLES, 12_000_000, idle cycles allowed in RUN before abort; counter width is clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx_ready  in  1  UART rx byte-valid pulse, 1 cycle
- rx_data  in  8  UART rx byte
- tx_active  in  1  UART tx busy
- tx_done  in  1  UART tx byte-complete pulse
- tx_data  out  8  byte to UART tx
- tx_start  out  1  UART tx start
- h_activate  out  N_HANDLERS  one-hot handler enable
- h_done  in  N_HANDLERS  handler done flags
- h_rx_ready  out  N_HANDLERS  rx_ready gated to the granted handler
- h_tx_data  in  8*N_HANDLERS  handler tx bytes, handler i at [8i+7:8i]
- h_tx_start  in  N_HANDLERS  handler tx start requests
- busy  out  1  high whenever state is not IDLE
- sel  out  clog2(N_HANDLERS)  index of the current or last granted handler
- err_cmd  out  1  1-cycle pulse on invalid command
- err_timeout  out  1  1-cycle pulse on handler abort

Behaviour:
- Reset is asynchronous. All outputs, state, sel, and the timeout counter go to 0 immediately; state = IDLE. Reset mid-RUN drops h_activate in the same instant.
- States: IDLE, RUN, RELEASE, NAK_WAIT, NAK_SEND.
- IDLE:
  - h_activate = 0, tx_start = 0, h_rx_ready = 0.
  - On rx_ready with rx_data < N_HANDLERS: sel <= rx_data[clog2-1:0], counter <= 0, go to RUN.
  - On rx_ready with rx_data >= N_HANDLERS: err_cmd pulse, go to NAK_WAIT.
  - The command byte is never forwarded to a handler.
- RUN:
  - h_activate[sel] = 1 (registered, so it asserts the cycle after the command byte).
  - h_rx_ready[sel] = rx_ready, combinational passthrough. All other h_rx_ready bits = 0.
  - tx_data = h_tx_data[sel], tx_start = h_tx_start[sel], both combinational. Non-granted handlers' tx requests are ignored.
  - Counter clears on rx_ready, h_tx_start[sel], or tx_active; otherwise it increments.
  - h_done[sel] = 1: go to RELEASE.
  - Else if counter == TIMEOUT_CYCLES-1: err_timeout pulse, go to IDLE directly, with h_activate cleared on the transition.
  - h_done and timeout in the same cycle: done wins, no error.
- RELEASE:
  - h_activate = 0, tx_start = 0.
  - Wait for h_done[sel] == 0, then go to IDLE. Handlers may hold done for several cycles after activate drops.
  - rx_ready arriving here is dropped.
- NAK_WAIT:
  - tx_start = 0. When tx_active == 0, go to NAK_SEND.
- NAK_SEND:
  - tx_data = NAK_BYTE, tx_start = 1 for exactly one cycle, then go to IDLE.
  - Any rx bytes received during NAK_WAIT/NAK_SEND are dropped.
- tx_data holds its last value whenever tx_start = 0. Its value is only meaningful while tx_start = 1.
- Only one h_activate bit is ever high, and only in RUN.
- busy = (state != IDLE).

Test Plan:
- Bench uses N=4, TIMEOUT=100, and a replayer-style handler on port 1.
- Valid command: send 0x01, then 0x41, 0x55 → h_activate = 4'b0010 from the cycle after 0x01; handler echoes 0x41 and 0x55 on tx; 0x01 itself is never echoed; after h_done the FSM passes RELEASE → IDLE, then busy = 0 and sel = 1.
- Invalid command: send 0x07 → err_cmd pulses once; h_activate stays 0; tx_start pulses once with tx_data = 0x15 only after tx_active is low.
- Timeout: send 0x02 with the port-2 handler silent → after 100 idle cycles err_timeout pulses, h_activate goes 0, state returns to IDLE; next command 0x00 is accepted normally.
- Isolation: in RUN on port 0, pulse h_tx_start[3] with h_tx_data[3] = 0xAA → tx_start stays 0 and 0xAA never appears on tx; rx bytes reach only h_rx_ready[0].
- Boundary: assert h_done[sel] on the same cycle the counter hits 99 → RELEASE is entered and err_timeout stays 0. Send a byte during RELEASE → it is dropped and not treated as a command.
- Reset mid-RUN: assert reset during port-1 echo → h_activate, tx_start, busy are 0 immediately; after release, 0x01 starts a clean session.
